// File: rtl/alu_flags.sv
// Flag staging and F register for a nibble-serial ALU.
// Stages per-nibble zero/carry and shift bits, then commits Z/N/H/C into F.
module alu_flags (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       nib_l,
  input  logic       nib_h,
  input  logic       nib_zero,
  input  logic       nib_cout,
  input  logic       shift_out,
  input  logic       shift_cap,
  input  logic [3:0] we,
  input  logic       n_val,
  input  logic [1:0] h_mode,
  input  logic [1:0] c_mode,
  input  logic       commit,
  input  logic       f_ld,
  input  logic [7:0] dbus,
  output logic [7:0] f,
  output logic [1:0] staged
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;

  logic [1:0] state, state_nx;
  logic lo_z, hi_z, lo_c, hi_c, sh_bit;
  logic lo_z_nx, hi_z_nx, lo_c_nx, hi_c_nx, sh_nx;
  logic fz, fn, fh, fc;
  logic fz_nx, fn_nx, fh_nx, fc_nx;
  logic [1:0] base;

  // Commit clears staging first; a coincident nibble capture lands on top.
  always_comb begin
    base     = commit ? IDLE : state;
    state_nx = base;
    lo_z_nx  = commit ? 1'b1 : lo_z;
    hi_z_nx  = commit ? 1'b1 : hi_z;
    lo_c_nx  = commit ? 1'b0 : lo_c;
    hi_c_nx  = commit ? 1'b0 : hi_c;
    sh_nx    = commit ? 1'b0 : sh_bit;
    if (nib_l) begin
      lo_z_nx  = nib_zero;
      lo_c_nx  = nib_cout;
      hi_z_nx  = 1'b1;
      hi_c_nx  = 1'b0;
      state_nx = LO;
    end else if (nib_h) begin
      if (base != LO) begin
        lo_z_nx = 1'b1;
        lo_c_nx = 1'b0;
      end
      hi_z_nx  = nib_zero;
      hi_c_nx  = nib_cout;
      state_nx = HI;
    end
    if (shift_cap)
      sh_nx = shift_out;
  end

  always_comb begin
    fz_nx = fz;
    fn_nx = fn;
    fh_nx = fh;
    fc_nx = fc;
    if (f_ld) begin
      {fz_nx, fn_nx, fh_nx, fc_nx} = dbus[7:4];
    end else if (commit) begin
      if (we[3]) fz_nx = lo_z & hi_z;
      if (we[2]) fn_nx = n_val;
      if (we[1]) begin
        unique case (h_mode)
          2'd0: fh_nx = lo_c;
          2'd1: fh_nx = 1'b0;
          2'd2: fh_nx = 1'b1;
          2'd3: fh_nx = fh;
        endcase
      end
      if (we[0]) begin
        unique case (c_mode)
          2'd0: fc_nx = hi_c;
          2'd1: fc_nx = sh_bit;
          2'd2: fc_nx = 1'b1;
          2'd3: fc_nx = ~fc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      lo_z   <= 1'b1;
      hi_z   <= 1'b1;
      lo_c   <= 1'b0;
      hi_c   <= 1'b0;
      sh_bit <= 1'b0;
      fz     <= 1'b0;
      fn     <= 1'b0;
      fh     <= 1'b0;
      fc     <= 1'b0;
    end else if (ce) begin
      state  <= state_nx;
      lo_z   <= lo_z_nx;
      hi_z   <= hi_z_nx;
      lo_c   <= lo_c_nx;
      hi_c   <= hi_c_nx;
      sh_bit <= sh_nx;
      fz     <= fz_nx;
      fn     <= fn_nx;
      fh     <= fh_nx;
      fc     <= fc_nx;
    end
  end

  assign f      = {fz, fn, fh, fc, 4'b0000};
  assign staged = state;

endmodule
